branch_predictor: RTL and testbench



---
 rtl/c16_pkg.sv | 24 ++
 rtl/branch_predictor_if.sv | 31 +++
 rtl/branch_predictor_sat_counter_next.sv | 22 ++
 rtl/branch_predictor.sv | 145 ++++++++++++++
 tb/tb_branch_predictor.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/c16_pkg.sv
// Shared definitions for the branch predictor slice.
//   PC_W_DEFAULT      : default PC / target width
//   sweep_state_e     : sweep FSM encoding (CLEAR, RUN)
//   ctr_wnt / ctr_wt  : weakly-not-taken / weakly-taken counter values for a counter width
package c16_pkg;

   localparam int unsigned PC_W_DEFAULT = 16;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } sweep_state_e;

   // Largest value whose MSB is 0: weakly not taken.
   function automatic int unsigned ctr_wnt(input int unsigned ctr_w);
      return (32'd1 << (ctr_w - 32'd1)) - 32'd1;
   endfunction

   // Smallest value whose MSB is 1: weakly taken.
   function automatic int unsigned ctr_wt(input int unsigned ctr_w);
      return 32'd1 << (ctr_w - 32'd1);
   endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch/execute-facing bundle of the branch predictor.
//   lookup_pc / pred_taken / pred_target : same-cycle fetch prediction
//   busy                                 : post-reset clearing sweep active
//   upd_*                                : resolved outcome from execute
//   mispredict_count                     : saturating mispredict total
// master = fetch/execute side, slave = predictor.
interface branch_predictor_if #(
   parameter int unsigned PC_W  = c16_pkg::PC_W_DEFAULT,
   parameter int unsigned CNT_W = 16
);
   logic [PC_W-1:0]  lookup_pc;
   logic             pred_taken;
   logic [PC_W-1:0]  pred_target;
   logic             busy;
   logic             upd_valid;
   logic [PC_W-1:0]  upd_pc;
   logic             upd_taken;
   logic [PC_W-1:0]  upd_target;
   logic             upd_mispred;
   logic [CNT_W-1:0] mispredict_count;

   modport master (
      output lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispred,
      input  pred_taken, pred_target, busy, mispredict_count
   );

   modport slave (
      input  lookup_pc, upd_valid, upd_pc, upd_taken, upd_target, upd_mispred,
      output pred_taken, pred_target, busy, mispredict_count
   );
endinterface

// File: rtl/branch_predictor_sat_counter_next.sv
// Next value of a saturating up/down counter.
//   ctr_i : current value
//   inc_i : 1 = increment (saturate at all-ones), 0 = decrement (saturate at 0)
//   ctr_o : saturated next value
module sat_counter_next #(
   parameter int unsigned CTR_W = 2
) (
   input  logic [CTR_W-1:0] ctr_i,
   input  logic             inc_i,
   output logic [CTR_W-1:0] ctr_o
);

   always_comb begin
      ctr_o = ctr_i;
      if (inc_i) begin
         if (ctr_i != '1) ctr_o = ctr_i + CTR_W'(1);
      end else begin
         if (ctr_i != '0) ctr_o = ctr_i - CTR_W'(1);
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Tagged branch target buffer with saturating-counter direction prediction.
//   clk, CPU_RESET_n : clock, synchronous active-low reset
//   bus (slave)      : lookup_pc -> pred_taken/pred_target (combinational),
//                      busy, upd_* resolved outcomes, mispredict_count
// After reset a sweep clears one entry per cycle; lookups predict not-taken and
// updates are dropped until the sweep finishes.
module branch_predictor
   import c16_pkg::*;
#(
   parameter int unsigned PC_W  = PC_W_DEFAULT,
   parameter int unsigned IDX_W = 6,
   parameter int unsigned TAG_W = 4,
   parameter int unsigned CTR_W = 2,
   parameter int unsigned CNT_W = 16
) (
   input logic               clk,
   input logic               CPU_RESET_n,
   branch_predictor_if.slave bus
);

   localparam int unsigned DEPTH = 32'd1 << IDX_W;
   localparam logic [CTR_W-1:0] CTR_WNT = CTR_W'(ctr_wnt(CTR_W));
   localparam logic [CTR_W-1:0] CTR_WT  = CTR_W'(ctr_wt(CTR_W));

   if (IDX_W + TAG_W > PC_W) begin : g_bad_fields
      $error("IDX_W + TAG_W must not exceed PC_W");
   end
   if (TAG_W < 1 || CTR_W < 2) begin : g_bad_widths
      $error("TAG_W must be >= 1 and CTR_W must be >= 2");
   end

   // Table storage, single write port
   logic             valid_q  [DEPTH];
   logic [TAG_W-1:0] tag_q    [DEPTH];
   logic [PC_W-1:0]  target_q [DEPTH];
   logic [CTR_W-1:0] ctr_q    [DEPTH];

   sweep_state_e     state_q;
   logic [IDX_W-1:0] ptr_q;
   logic [CNT_W-1:0] mis_cnt_q;

   // Sweep FSM: CLEAR walks ptr over every entry once, then RUN until reset
   always_ff @(posedge clk) begin
      if (!CPU_RESET_n) begin
         state_q <= ST_CLEAR;
         ptr_q   <= '0;
      end else if (state_q == ST_CLEAR) begin
         ptr_q <= ptr_q + IDX_W'(1);
         if (ptr_q == '1) state_q <= ST_RUN;
      end
   end

   // Lookup path
   logic [IDX_W-1:0] lk_idx_c;
   logic [TAG_W-1:0] lk_tag_c;
   logic             lk_hit_c;
   logic             lk_taken_c;

   assign lk_idx_c   = bus.lookup_pc[IDX_W-1:0];
   assign lk_tag_c   = bus.lookup_pc[IDX_W +: TAG_W];
   assign lk_hit_c   = valid_q[lk_idx_c] && (tag_q[lk_idx_c] == lk_tag_c);
   assign lk_taken_c = (state_q == ST_RUN) && lk_hit_c && ctr_q[lk_idx_c][CTR_W-1];

   assign bus.pred_taken  = lk_taken_c;
   assign bus.pred_target = lk_taken_c ? target_q[lk_idx_c] : bus.lookup_pc + PC_W'(1);
   assign bus.busy        = (state_q == ST_CLEAR);

   // Update path
   logic [IDX_W-1:0] upd_idx_c;
   logic [TAG_W-1:0] upd_tag_c;
   logic             upd_hit_c;
   logic [CTR_W-1:0] ctr_next_c;

   assign upd_idx_c = bus.upd_pc[IDX_W-1:0];
   assign upd_tag_c = bus.upd_pc[IDX_W +: TAG_W];
   assign upd_hit_c = valid_q[upd_idx_c] && (tag_q[upd_idx_c] == upd_tag_c);

   sat_counter_next #(.CTR_W(CTR_W)) u_upd_ctr (
      .ctr_i (ctr_q[upd_idx_c]),
      .inc_i (bus.upd_taken),
      .ctr_o (ctr_next_c)
   );

   // PC bits above the tag field never reach the table
   logic unused_upd_pc_c;
   assign unused_upd_pc_c = ^bus.upd_pc;

   // Write-port arbitration: the sweep owns the port while clearing
   logic             wr_en_c;
   logic [IDX_W-1:0] wr_idx_c;
   logic             wr_valid_c;
   logic [TAG_W-1:0] wr_tag_c;
   logic [PC_W-1:0]  wr_target_c;
   logic [CTR_W-1:0] wr_ctr_c;

   always_comb begin
      wr_en_c     = 1'b0;
      wr_idx_c    = ptr_q;
      wr_valid_c  = 1'b0;
      wr_tag_c    = '0;
      wr_target_c = '0;
      wr_ctr_c    = CTR_WNT;
      if (state_q == ST_CLEAR) begin
         wr_en_c = 1'b1;
      end else if (bus.upd_valid) begin
         wr_idx_c = upd_idx_c;
         if (upd_hit_c) begin
            wr_en_c     = 1'b1;
            wr_valid_c  = 1'b1;
            wr_tag_c    = upd_tag_c;
            wr_target_c = bus.upd_taken ? bus.upd_target : target_q[upd_idx_c];
            wr_ctr_c    = ctr_next_c;
         end else if (bus.upd_taken) begin
            // Allocate, replacing whatever occupied the slot
            wr_en_c     = 1'b1;
            wr_valid_c  = 1'b1;
            wr_tag_c    = upd_tag_c;
            wr_target_c = bus.upd_target;
            wr_ctr_c    = CTR_WT;
         end
      end
   end

   // Table write port (contents are defined by the sweep, so no reset)
   always_ff @(posedge clk) begin
      if (wr_en_c) begin
         valid_q[wr_idx_c]  <= wr_valid_c;
         tag_q[wr_idx_c]    <= wr_tag_c;
         target_q[wr_idx_c] <= wr_target_c;
         ctr_q[wr_idx_c]    <= wr_ctr_c;
      end
   end

   // Mispredict counter counts even while the sweep runs
   always_ff @(posedge clk) begin
      if (!CPU_RESET_n) begin
         mis_cnt_q <= '0;
      end else if (bus.upd_valid && bus.upd_mispred && (mis_cnt_q != '1)) begin
         mis_cnt_q <= mis_cnt_q + CNT_W'(1);
      end
   end

   assign bus.mispredict_count = mis_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
module tb_branch_predictor;

   localparam int unsigned PC_W  = 16;
   localparam int unsigned CNT_W = 4;
   localparam int unsigned SAT   = 15;

   logic clk;
   logic rst_n;

   branch_predictor_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

   branch_predictor #(
      .PC_W(PC_W), .IDX_W(6), .TAG_W(4), .CTR_W(2), .CNT_W(CNT_W)
   ) dut (
      .clk         (clk),
      .CPU_RESET_n (rst_n),
      .bus         (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit          is_upd;
      logic [15:0] pc;
      bit          taken;
      logic [15:0] target;
      bit          mispred;
      bit          exp_taken;
      logic [15:0] exp_target;
      string       name;
   } vec_t;

   typedef struct {
      string       name;
      bit          taken;
      logic [15:0] target;
   } exp_t;

   vec_t vecs[$];
   exp_t sb_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   exp_mis = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Drive a lookup, queue its expectation, compare mid-cycle
   task automatic lookup_check(input logic [15:0] pc, input bit taken,
                               input logic [15:0] target, input string name);
      exp_t e;
      bus.lookup_pc = pc;
      sb_q.push_back('{name: name, taken: taken, target: target});
      @(negedge clk);
      e = sb_q.pop_front();
      check({e.name, "_taken"},  32'(bus.pred_taken),  32'(e.taken));
      check({e.name, "_target"}, 32'(bus.pred_target), 32'(e.target));
   endtask

   task automatic apply_update(input logic [15:0] pc, input bit taken,
                               input logic [15:0] target, input bit mispred);
      bus.upd_valid   = 1'b1;
      bus.upd_pc      = pc;
      bus.upd_taken   = taken;
      bus.upd_target  = target;
      bus.upd_mispred = mispred;
      if (mispred && exp_mis < int'(SAT)) exp_mis++;
      tick();
      bus.upd_valid   = 1'b0;
      bus.upd_mispred = 1'b0;
   endtask

   task automatic add_u(input logic [15:0] pc, input bit t, input logic [15:0] tg, input bit m);
      vecs.push_back('{is_upd: 1'b1, pc: pc, taken: t, target: tg, mispred: m,
                       exp_taken: 1'b0, exp_target: 16'h0, name: "upd"});
   endtask

   task automatic add_l(input logic [15:0] pc, input bit et, input logic [15:0] etg, input string n);
      vecs.push_back('{is_upd: 1'b0, pc: pc, taken: 1'b0, target: 16'h0, mispred: 1'b0,
                       exp_taken: et, exp_target: etg, name: n});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int n;

      add_l(16'h0005, 0, 16'h0006, "sweep_drop");
      add_u(16'h0005, 1, 16'h0002, 0);
      add_l(16'h0005, 1, 16'h0002, "alloc");
      add_u(16'h0005, 1, 16'h0002, 0);
      add_u(16'h0005, 1, 16'h0002, 1);
      add_u(16'h0005, 0, 16'h0000, 1);
      add_l(16'h0005, 1, 16'h0002, "sat_hold");
      add_u(16'h0005, 0, 16'h0000, 0);
      add_l(16'h0005, 0, 16'h0006, "train_back");
      add_u(16'h0005, 1, 16'h0003, 0);
      add_l(16'h0005, 1, 16'h0003, "retarget");
      add_l(16'h0045, 0, 16'h0046, "alias_miss");
      add_u(16'h0045, 1, 16'h0100, 0);
      add_l(16'h0045, 1, 16'h0100, "alias_alloc");
      add_l(16'h0005, 0, 16'h0006, "evicted");
      add_u(16'h0045, 0, 16'h0000, 0);
      add_l(16'h0045, 0, 16'h0046, "alloc_is_wt");
      add_u(16'h0007, 0, 16'h0000, 0);
      add_l(16'h0007, 0, 16'h0008, "miss_nt_noalloc");
      add_u(16'h0007, 1, 16'h1234, 0);
      add_l(16'h0007, 1, 16'h1234, "alloc2");
      add_l(16'hFFFF, 0, 16'h0000, "wrap");

      rst_n           = 1'b0;
      bus.lookup_pc   = 16'h0;
      bus.upd_valid   = 1'b0;
      bus.upd_pc      = 16'h0;
      bus.upd_taken   = 1'b0;
      bus.upd_target  = 16'h0;
      bus.upd_mispred = 1'b0;

      tick();
      tick();
      check("rst_busy", 32'(bus.busy), 32'd1);
      check("rst_mis",  32'(bus.mispredict_count), 32'd0);
      lookup_check(16'h0010, 0, 16'h0011, "rst_lookup");
      rst_n = 1'b1;

      // Sweep: busy for 64 edges; an update at cycle 10 must be dropped
      for (int cyc = 1; cyc <= 66; cyc++) begin
         tick();
         bus.upd_valid   = (cyc == 10);
         bus.upd_mispred = (cyc == 10);
         bus.upd_pc      = 16'h0005;
         bus.upd_taken   = 1'b1;
         bus.upd_target  = 16'h0002;
         if (cyc == 10) exp_mis++;
         check($sformatf("sweep_busy_%0d", cyc), 32'(bus.busy), 32'(cyc < 64));
         if (cyc == 20) lookup_check(16'h0010, 0, 16'h0011, "sweep_lookup");
      end
      check("sweep_mis", 32'(bus.mispredict_count), 32'(exp_mis));

      foreach (vecs[i]) begin
         if (vecs[i].is_upd) begin
            apply_update(vecs[i].pc, vecs[i].taken, vecs[i].target, vecs[i].mispred);
         end else begin
            lookup_check(vecs[i].pc, vecs[i].exp_taken, vecs[i].exp_target, vecs[i].name);
            tick();
         end
      end
      check("table_mis", 32'(bus.mispredict_count), 32'(exp_mis));

      // Same-cycle lookup of the entry being written sees old contents
      bus.upd_valid  = 1'b1;
      bus.upd_pc     = 16'h0009;
      bus.upd_taken  = 1'b1;
      bus.upd_target = 16'h0040;
      lookup_check(16'h0009, 0, 16'h000A, "no_bypass");
      tick();
      bus.upd_valid = 1'b0;
      lookup_check(16'h0009, 1, 16'h0040, "upd_visible");
      tick();

      // Mispredict counter saturation
      for (int k = 0; k < 20; k++) apply_update(16'h0030, 0, 16'h0000, 1);
      check("mis_sat", 32'(bus.mispredict_count), 32'(SAT));
      check("mis_model", 32'(exp_mis), 32'(bus.mispredict_count));
      lookup_check(16'h0030, 0, 16'h0031, "mis_noalloc");
      tick();

      // Reset mid-sweep restarts the full sweep
      rst_n = 1'b0;
      exp_mis = 0;
      tick();
      check("rst2_busy", 32'(bus.busy), 32'd1);
      check("rst2_mis",  32'(bus.mispredict_count), 32'd0);
      rst_n = 1'b1;
      for (int k = 0; k < 30; k++) tick();
      check("mid_sweep_busy", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
      end while (bus.busy && n < 200);
      check("busy_len", 32'(n), 32'd64);
      lookup_check(16'h0007, 0, 16'h0008, "cleared_after_reset");
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
